// File: rtl/pipe_stage_fifo.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer with valid/ready handshake,
// one-cycle flush, commit-order tag on the head entry and a saturating stall counter.
module pipe_stage_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 2,
  parameter int ORDER_W = 64,
  parameter int STALL_W = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [ORDER_W-1:0]         out_order,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [STALL_W-1:0]         stall_cnt
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem_reg [DEPTH];
  logic [PW-1:0]      rd_ptr_reg;
  logic [PW-1:0]      wr_ptr_reg;
  logic [CW-1:0]      count_reg;
  logic [ORDER_W-1:0] order_reg;
  logic [STALL_W-1:0] stall_reg;
  logic [WIDTH-1:0]   head_data;
  logic               enq;
  logic               deq;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Ready and valid look only at occupancy and flush, so there is no
  // combinational path from out_ready to in_ready.
  assign in_ready  = (count_reg < CW'(DEPTH)) && !flush;
  assign out_valid = (count_reg != '0) && !flush;
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  generate
    if (DEPTH == 1) begin : g_head_single
      assign head_data = mem_reg[0];
    end else begin : g_head_multi
      assign head_data = mem_reg[rd_ptr_reg];
    end
  endgenerate

  assign out_data  = out_valid ? head_data : '0;
  assign out_order = order_reg;
  assign count     = count_reg;
  assign stall_cnt = stall_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (deq) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({enq, deq})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Flushed beats never dequeue, so they consume no order number.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      order_reg <= '0;
    end else if (deq) begin
      order_reg <= order_reg + ORDER_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_reg <= '0;
    end else if (out_valid && !out_ready && (stall_reg != '1)) begin
      stall_reg <= stall_reg + STALL_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          mem_reg[gi] <= '0;
        end else if (enq && (wr_ptr_reg == PW'(gi))) begin
          mem_reg[gi] <= in_data;
        end
      end
    end
  endgenerate

endmodule
